// File: rtl/db9_pkg.sv
// Shared constants for the DB9 Mega Drive pad scanner: output bit layout,
// DB9 pin indices and scanner FSM state encodings.
package db9_pkg;

  // Published button word bit positions (active-high)
  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_MODE  = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_Y     = 10;
  localparam int BTN_Z     = 11;

  // DB9 bus pin positions on joy_in (active-low)
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_TL    = 4;
  localparam int PIN_TR    = 5;

  // Scanner FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  // Steps per player pass
  localparam logic [2:0] LAST_STEP = 3'd7;

endpackage

// File: rtl/db9_step_timer.sv
// Step and frame timing for the DB9 scanner. The step counter runs only while
// the scanner is in SCAN and strobes on the last cycle of each step; the frame
// counter restarts on scan entry and saturates at its terminal count.
module db9_step_timer #(
  parameter int STEP_CYCLES  = 500,
  parameter int FRAME_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_frame_restart,
  input  logic i_step_run,
  output logic o_step_end,
  output logic o_frame_end
);

  localparam int SW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam int FW = $clog2(FRAME_CYCLES);

  logic [SW-1:0] r_step_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic          w_step_last;
  logic          w_frame_last;

  assign w_step_last  = (r_step_cnt == SW'(STEP_CYCLES - 1));
  assign w_frame_last = (r_frame_cnt == FW'(FRAME_CYCLES - 1));
  assign o_step_end   = i_step_run && w_step_last;
  assign o_frame_end  = w_frame_last;

  // Step counter: idles at 0 outside SCAN, wraps at the end of every step
  always_ff @(posedge i_clk) begin
    if (i_clear || !i_step_run || w_step_last)
      r_step_cnt <= '0;
    else
      r_step_cnt <= r_step_cnt + SW'(1);
  end

  // Frame counter: zeroed on scan entry, holds at terminal count until used
  always_ff @(posedge i_clk) begin
    if (i_clear || i_frame_restart)
      r_frame_cnt <= '0;
    else if (!w_frame_last)
      r_frame_cnt <= r_frame_cnt + FW'(1);
  end

endmodule

// File: rtl/db9_md_scanner.sv
// Two-player DB9 Mega Drive / Atari pad scanner. Multiplexes the shared bus
// with joy_split, drives the MD select line, captures each player into a
// shadow word and publishes both words together once per frame.
import db9_pkg::*;

module db9_md_scanner #(
  parameter int STEP_CYCLES  = 500,
  parameter int FRAME_CYCLES = 100000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  joy_in,
  output logic        joy_split,
  output logic        joy_mdsel,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad6,
  output logic        scan_done
);

  logic [1:0]       r_state;
  logic             r_player;
  logic [2:0]       r_step;
  logic             r_settle;
  logic [1:0][11:0] r_shadow;
  logic [1:0]       r_six;
  logic [15:0]      r_joy1;
  logic [15:0]      r_joy2;
  logic [1:0]       r_pad6;
  logic             r_scan_done;

  logic       w_clear;
  logic       w_scan;
  logic       w_start;
  logic       w_step_end;
  logic       w_frame_end;
  logic       w_sample;
  logic [5:0] w_inv;
  logic       w_md_id;
  logic       w_six_id;

  // Disable behaves exactly like reset, every cycle it is low
  assign w_clear  = reset || !enable;
  assign w_scan   = (r_state == ST_SCAN);
  assign w_start  = (r_state == ST_IDLE) && w_frame_end;
  assign w_sample = w_scan && w_step_end && !r_settle;
  assign w_inv    = ~joy_in;
  // MD pads pull Left and Right low while select is low
  assign w_md_id  = !joy_in[PIN_LEFT] && !joy_in[PIN_RIGHT];
  // Six-button pads pull all directions low on the third select-low phase
  assign w_six_id = (joy_in[PIN_RIGHT:PIN_UP] == 4'b0000);

  db9_step_timer #(
    .STEP_CYCLES  (STEP_CYCLES),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_timer (
    .i_clk           (clk_sys),
    .i_clear         (w_clear),
    .i_frame_restart (w_start),
    .i_step_run      (w_scan),
    .o_step_end      (w_step_end),
    .o_frame_end     (w_frame_end)
  );

  // Select is high on even steps and during the inter-player settle step
  assign joy_mdsel = (w_scan && !r_settle) ? ~r_step[0] : 1'b1;
  // Player 2 is routed only while its pass (including settle) is active
  assign joy_split = !(w_scan && r_player);
  assign joystick1 = r_joy1;
  assign joystick2 = r_joy2;
  assign pad6      = r_pad6;
  assign scan_done = r_scan_done;

  // Scan sequencer: IDLE -> P1 steps -> settle -> P2 steps -> PUBLISH
  always_ff @(posedge clk_sys) begin
    if (w_clear) begin
      r_state  <= ST_IDLE;
      r_player <= 1'b0;
      r_step   <= 3'd0;
      r_settle <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_frame_end) begin
            r_state  <= ST_SCAN;
            r_player <= 1'b0;
            r_step   <= 3'd0;
            r_settle <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_step_end) begin
            if (r_settle) begin
              r_settle <= 1'b0;
              r_step   <= 3'd0;
            end else if (r_step == LAST_STEP) begin
              if (!r_player) begin
                r_player <= 1'b1;
                r_settle <= 1'b1;
                r_step   <= 3'd0;
              end else begin
                r_state <= ST_PUBLISH;
              end
            end else begin
              r_step <= r_step + 3'd1;
            end
          end
        end
        ST_PUBLISH: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the bus into the active player's shadow on the last cycle of a step
  always_ff @(posedge clk_sys) begin
    if (w_clear || w_start) begin
      r_shadow <= '0;
      r_six    <= 2'b00;
    end else if (w_sample) begin
      case (r_step)
        3'd0: begin
          r_shadow[r_player][BTN_U] <= w_inv[PIN_UP];
          r_shadow[r_player][BTN_D] <= w_inv[PIN_DOWN];
          r_shadow[r_player][BTN_L] <= w_inv[PIN_LEFT];
          r_shadow[r_player][BTN_R] <= w_inv[PIN_RIGHT];
          r_shadow[r_player][BTN_B] <= w_inv[PIN_TL];
          r_shadow[r_player][BTN_C] <= w_inv[PIN_TR];
        end
        3'd1: begin
          if (w_md_id) begin
            r_shadow[r_player][BTN_A]     <= w_inv[PIN_TL];
            r_shadow[r_player][BTN_START] <= w_inv[PIN_TR];
          end
        end
        3'd5: r_six[r_player] <= w_six_id;
        3'd6: begin
          if (r_six[r_player]) begin
            r_shadow[r_player][BTN_Z]    <= w_inv[PIN_UP];
            r_shadow[r_player][BTN_Y]    <= w_inv[PIN_DOWN];
            r_shadow[r_player][BTN_X]    <= w_inv[PIN_LEFT];
            r_shadow[r_player][BTN_MODE] <= w_inv[PIN_RIGHT];
          end
        end
        default: ;
      endcase
    end
  end

  // Publish both shadows together; scan_done pulses for one cycle
  always_ff @(posedge clk_sys) begin
    if (w_clear) begin
      r_joy1      <= 16'h0000;
      r_joy2      <= 16'h0000;
      r_pad6      <= 2'b00;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= (r_state == ST_PUBLISH);
      if (r_state == ST_PUBLISH) begin
        r_joy1 <= {4'h0, r_shadow[0]};
        r_joy2 <= {4'h0, r_shadow[1]};
        r_pad6 <= r_six;
      end
    end
  end

endmodule

// File: tb/tb_db9_md_scanner.sv
// Scoreboard bench for db9_md_scanner with behavioural 3/6-button pad models.
module tb_db9_md_scanner;

  localparam int STEP  = 4;
  localparam int FRAME = 80;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        enable  = 1'b0;
  logic [5:0]  joy_in;
  logic        joy_split;
  logic        joy_mdsel;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  pad6;
  logic        scan_done;

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [1:0]  p6;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Pad models: hi = sel high, lo = sel low, lo3/hi3 = third low phase and
  // the following high phase of a six-button pad
  logic [5:0] p1_hi = 6'h00, p1_lo = 6'h00, p1_lo3 = 6'h00, p1_hi3 = 6'h00;
  logic [5:0] p2_hi = 6'h00, p2_lo = 6'h00, p2_lo3 = 6'h00, p2_hi3 = 6'h00;
  logic       p1_six = 1'b0, p2_six = 1'b0;
  int         c1 = 0, c2 = 0;
  logic       prev_sel = 1'b1, prev_split = 1'b1;

  db9_md_scanner #(.STEP_CYCLES(STEP), .FRAME_CYCLES(FRAME)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .enable    (enable),
    .joy_in    (joy_in),
    .joy_split (joy_split),
    .joy_mdsel (joy_mdsel),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .pad6      (pad6),
    .scan_done (scan_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Per-pad count of select-low phases, restarted when the pad is routed in
  always @(joy_mdsel or joy_split) begin
    if (joy_split && !prev_split) c1 = 0;
    if (!joy_split && prev_split) c2 = 0;
    if (prev_sel && !joy_mdsel) begin
      if (joy_split) c1 = c1 + 1;
      else           c2 = c2 + 1;
    end
    prev_sel   = joy_mdsel;
    prev_split = joy_split;
  end

  always_comb begin
    if (joy_split)
      joy_in = joy_mdsel ? ((p1_six && c1 == 3) ? p1_hi3 : p1_hi)
                         : ((p1_six && c1 == 3) ? p1_lo3 : p1_lo);
    else
      joy_in = joy_mdsel ? ((p2_six && c2 == 3) ? p2_hi3 : p2_hi)
                         : ((p2_six && c2 == 3) ? p2_lo3 : p2_lo);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic set_p1(input logic [5:0] hi, input logic [5:0] lo, input logic six,
                        input logic [5:0] lo3, input logic [5:0] hi3);
    p1_hi = hi; p1_lo = lo; p1_six = six; p1_lo3 = lo3; p1_hi3 = hi3;
  endtask

  task automatic set_p2(input logic [5:0] hi, input logic [5:0] lo, input logic six,
                        input logic [5:0] lo3, input logic [5:0] hi3);
    p2_hi = hi; p2_lo = lo; p2_six = six; p2_lo3 = lo3; p2_hi3 = hi3;
  endtask

  task automatic push_exp(input logic [15:0] j1, input logic [15:0] j2, input logic [1:0] p6);
    exp_t e;
    e.j1 = j1; e.j2 = j2; e.p6 = p6;
    exp_q.push_back(e);
  endtask

  // Bounded wait for scan_done, sampled on the falling edge
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_sys);
      cyc++;
    end while (!scan_done && cyc < 400);
    if (!scan_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scan_done timeout got none expected strobe", name);
    end
  endtask

  // Monitor: every scan_done pops one expected publish and compares
  initial begin
    forever begin
      @(negedge clk_sys);
      if (scan_done) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL publish: unexpected scan_done j1=%h j2=%h pad6=%b", joystick1, joystick2, pad6);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (joystick1 !== e.j1 || joystick2 !== e.j2 || pad6 !== e.p6) begin
            n_fail++;
            $display("FAIL publish: got j1=%h j2=%h pad6=%b expected j1=%h j2=%h pad6=%b",
                     joystick1, joystick2, pad6, e.j1, e.j2, e.p6);
          end
        end
      end
    end
  end

  initial begin
    int   cyc;
    int   bad;
    int   f;
    int   b;
    logic tr_split [1:80];
    logic tr_sel   [1:80];
    logic tr_done  [1:80];
    logic es, em, ed;

    // Reset, bus all low
    repeat (3) @(negedge clk_sys);
    chk("rst_j1", {16'h0, joystick1}, 32'h0);
    chk("rst_j2", {16'h0, joystick2}, 32'h0);
    chk("rst_pins", {28'h0, pad6, joy_split, joy_mdsel}, {28'h0, 2'b00, 1'b1, 1'b1});
    chk("rst_done", {31'h0, scan_done}, 32'h0);

    // Reset released but enable low: everything stays in reset state
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (joystick1 !== 16'h0 || joystick2 !== 16'h0 || pad6 !== 2'b00 ||
          scan_done !== 1'b0 || joy_split !== 1'b1 || joy_mdsel !== 1'b1) bad++;
    end
    chk("en0_hold", bad, 0);

    // 3-button P1: Up + C; P2 absent
    set_p1(6'b011110, 6'b110011, 1'b0, 6'h3f, 6'h3f);
    set_p2(6'h3f, 6'h3f, 1'b0, 6'h3f, 6'h3f);
    push_exp(16'h0028, 16'h0000, 2'b00);
    enable = 1'b1;
    wait_done("scan_3btn", cyc);

    // 6-button P2 with Z only; P1 absent
    set_p1(6'h3f, 6'h3f, 1'b0, 6'h3f, 6'h3f);
    set_p2(6'h3f, 6'b110011, 1'b1, 6'b110000, 6'b111110);
    push_exp(16'h0000, 16'h0800, 2'b10);
    wait_done("scan_6btn", cyc);

    // Both pads: P1 six-button B,C,A,Start,Z,Y,X,Mode; P2 3-button Start
    set_p1(6'b001111, 6'b000011, 1'b1, 6'b000000, 6'b000000);
    set_p2(6'h3f, 6'b010011, 1'b0, 6'h3f, 6'h3f);
    push_exp(16'h0FF0, 16'h0080, 2'b01);
    wait_done("scan_both", cyc);

    // Timing: record one full frame following a scan_done
    push_exp(16'h0FF0, 16'h0080, 2'b01);
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk_sys);
      tr_split[i] = joy_split;
      tr_sel[i]   = joy_mdsel;
      tr_done[i]  = scan_done;
    end
    f = 0;
    for (int i = 80; i >= 1; i--) if (tr_sel[i] == 1'b0) f = i;
    b = f - STEP;
    chk("scan_found", {31'h0, (b >= 1 && b + 17 * STEP <= 80)}, 32'h1);
    bad = 0;
    for (int i = 1; i <= 80; i++) begin
      es = 1'b1; em = 1'b1;
      if (i >= b && i < b + 8 * STEP) begin
        em = ~(((i - b) / STEP) % 2 == 1);
      end else if (i >= b + 8 * STEP && i < b + 9 * STEP) begin
        es = 1'b0;
      end else if (i >= b + 9 * STEP && i < b + 17 * STEP) begin
        es = 1'b0;
        em = ~(((i - b - 9 * STEP) / STEP) % 2 == 1);
      end
      if (tr_split[i] !== es || tr_sel[i] !== em) bad++;
    end
    chk("sel_split_wave", bad, 0);
    bad = 0;
    for (int i = 1; i <= 80; i++) begin
      ed = (i == FRAME);
      if (tr_done[i] !== ed) bad++;
    end
    chk("done_period", bad, 0);

    // Reset during P2 step 3 with nonzero outputs
    cyc = 0;
    while (joy_split && cyc < 200) begin
      @(negedge clk_sys);
      cyc++;
    end
    chk("split_fall", {31'h0, joy_split}, 32'h0);
    repeat (4 * STEP) @(negedge clk_sys);
    chk("at_p1_s3", {30'h0, joy_split, joy_mdsel}, 32'h0);
    reset = 1'b1;
    set_p1(6'b011111, 6'b011111, 1'b0, 6'h3f, 6'h3f);
    set_p2(6'h3f, 6'h3f, 1'b0, 6'h3f, 6'h3f);
    @(negedge clk_sys);
    chk("midrst_j1", {16'h0, joystick1}, 32'h0);
    chk("midrst_j2", {16'h0, joystick2}, 32'h0);
    chk("midrst_pins", {27'h0, pad6, joy_split, joy_mdsel, scan_done},
        {27'h0, 2'b00, 1'b1, 1'b1, 1'b0});
    // Non-MD P1 (TR low only) on the first scan after reset
    push_exp(16'h0020, 16'h0000, 2'b00);
    reset = 1'b0;
    wait_done("scan_after_rst", cyc);
    chk("rst_latency", {31'h0, (cyc > FRAME && cyc <= 2 * FRAME)}, 32'h1);

    // Dropping enable clears the published words
    enable = 1'b0;
    @(negedge clk_sys);
    chk("en0_clear", {joystick1, joystick2}, 32'h0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
